// File: rtl/sm_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// sm_fetch_queue_if
// Bundles the fetch unit's instruction-memory port, redirect input, dequeue
// request and the two-wide issue window.
//   master : the fetch unit (drives imem_addr and the out_* issue window)
//   slave  : memory / issue stage side (drives imem_rd*, redirect*, deq)
// Signals:
//   imem_addr   word address to instruction memory
//   imem_rd1/2  words at imem_addr and imem_addr+1 (asynchronous read)
//   redirect    taken branch/jump, flush and refetch from redirect_pc
//   redirect_pc new byte PC, bits [1:0] ignored
//   deq         instructions consumed by issue this cycle (0..2)
//   out_*       head / head+1 issue window (NOP and pc 0 when not valid)
// ----------------------------------------------------------------------------
interface sm_fetch_queue_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd1;
   logic [31:0] imem_rd2;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [1:0]  deq;
   logic        out_valid0;
   logic        out_valid1;
   logic [31:0] out_instr0;
   logic [31:0] out_instr1;
   logic [31:0] out_pc0;
   logic [31:0] out_pc1;

   modport master (
      output imem_addr,
      input  imem_rd1,
      input  imem_rd2,
      input  redirect,
      input  redirect_pc,
      input  deq,
      output out_valid0,
      output out_valid1,
      output out_instr0,
      output out_instr1,
      output out_pc0,
      output out_pc1
   );

   modport slave (
      input  imem_addr,
      output imem_rd1,
      output imem_rd2,
      output redirect,
      output redirect_pc,
      output deq,
      input  out_valid0,
      input  out_valid1,
      input  out_instr0,
      input  out_instr1,
      input  out_pc0,
      input  out_pc1
   );
endinterface

// File: rtl/sm_fetch_queue.sv
// ----------------------------------------------------------------------------
// sm_fetch_queue
// Dual-issue instruction fetch unit. Reads two consecutive words per cycle
// from an asynchronous instruction memory, stores them with their byte PCs
// in a circular queue and offers up to two in-order instructions per cycle.
// A redirect flushes the queue and restarts fetching at the new PC.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (flushes queue, fetch_pc=RESET_PC)
//   bus    sm_fetch_queue_if.master: imem port, redirect, deq, issue window
//
// Parameters:
//   DEPTH       queue entries (power of two, >= 2)
//   IMEM_WORDS  instruction memory size in words; fetch address wraps
//   RESET_PC    byte PC of the first fetch after reset
//
// Build option:
//   SM_FETCH_BYPASS_EN  when defined, an empty queue shows the words being
//                       fetched this cycle directly on the issue window.
// ----------------------------------------------------------------------------
module sm_fetch_queue #(
   parameter int          DEPTH      = 4,
   parameter int          IMEM_WORDS = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   sm_fetch_queue_if.master  bus
);

   localparam int          PW        = $clog2(DEPTH);
   localparam int          CW        = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [29:0] LAST_WORD = 30'(IMEM_WORDS - 1);

   logic [31:0]   fetch_pc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [31:0]   q_instr [DEPTH];
   logic [31:0]   q_pc    [DEPTH];

   logic [29:0]   fetch_word;
   logic [31:0]   pc_plus4;
   logic          at_end;
   logic [1:0]    deq_req;
   logic [1:0]    wlim;
   logic [1:0]    deq_eff;
   logic [1:0]    pop;
   logic [1:0]    enq;
   logic [1:0]    adv;
   logic [CW:0]   space;
   logic          skip_rd1;
   logic          bypass_act;
   logic [29:0]   next_word;
   logic [31:0]   redir_mod;
   logic [PW-1:0] head1;
   logic [PW-1:0] tail1;
   logic          unused_pc_lsbs;

   assign fetch_word     = fetch_pc[31:2];
   assign pc_plus4       = fetch_pc + 32'd4;
   assign at_end         = (fetch_word == LAST_WORD);
   assign head1          = head + PW'(1);
   assign tail1          = tail + PW'(1);
   assign bus.imem_addr  = {2'b00, fetch_word};
   assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

   // deq is specified as 0..2; an out-of-range 3 is treated as 2.
   assign deq_req = (bus.deq == 2'd3) ? 2'd2 : bus.deq;

   // Redirect target wraps into the instruction memory.
   assign redir_mod = 32'(bus.redirect_pc[31:2]) % 32'(IMEM_WORDS);

   always_comb begin
      // rd2 would read past the last memory word, so only one word is usable.
      wlim       = at_end ? 2'd1 : 2'd2;
      deq_eff    = (CW'(deq_req) > count) ? 2'(count) : deq_req;
      pop        = deq_eff;
      space      = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(deq_eff);
      enq        = wlim;
      if (space < (CW+1)'(wlim)) begin
         enq = 2'(space);
      end
      adv        = enq;
      skip_rd1   = 1'b0;
      bypass_act = 1'b0;
`ifdef SM_FETCH_BYPASS_EN
      // Empty queue: the fetched words are consumed straight off the bus.
      // Nothing leaves the queue; only words not taken this cycle are stored.
      if ((count == '0) && !bus.redirect) begin
         bypass_act = 1'b1;
         deq_eff    = (deq_req > wlim) ? wlim : deq_req;
         pop        = 2'd0;
         enq        = wlim - deq_eff;
         adv        = wlim;
         skip_rd1   = (deq_eff != 2'd0);
      end
`endif
      // adv <= wlim, so the word index reaches IMEM_WORDS at most and wraps to 0.
      next_word = fetch_word + 30'(adv);
      if (next_word == 30'(IMEM_WORDS)) begin
         next_word = '0;
      end
   end

   // Control state: pointers, occupancy and fetch PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (bus.redirect) begin
         fetch_pc <= {redir_mod[29:0], 2'b00};
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         fetch_pc <= {next_word, 2'b00};
         head     <= head + PW'(pop);
         tail     <= tail + PW'(enq);
         count    <= count - CW'(pop) + CW'(enq);
      end
   end

   // Queue storage carries no reset; occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (!bus.redirect) begin
         if (enq != 2'd0) begin
            q_instr[tail] <= skip_rd1 ? bus.imem_rd2 : bus.imem_rd1;
            q_pc[tail]    <= skip_rd1 ? pc_plus4     : fetch_pc;
         end
         if (enq == 2'd2) begin
            q_instr[tail1] <= bus.imem_rd2;
            q_pc[tail1]    <= pc_plus4;
         end
      end
   end

   always_comb begin
      bus.out_valid0 = 1'b0;
      bus.out_valid1 = 1'b0;
      bus.out_instr0 = NOP;
      bus.out_instr1 = NOP;
      bus.out_pc0    = 32'd0;
      bus.out_pc1    = 32'd0;
      if (bypass_act) begin
         bus.out_valid0 = 1'b1;
         bus.out_instr0 = bus.imem_rd1;
         bus.out_pc0    = fetch_pc;
         if (wlim == 2'd2) begin
            bus.out_valid1 = 1'b1;
            bus.out_instr1 = bus.imem_rd2;
            bus.out_pc1    = pc_plus4;
         end
      end else begin
         if (count >= CW'(1)) begin
            bus.out_valid0 = 1'b1;
            bus.out_instr0 = q_instr[head];
            bus.out_pc0    = q_pc[head];
         end
         if (count >= CW'(2)) begin
            bus.out_valid1 = 1'b1;
            bus.out_instr1 = q_instr[head1];
            bus.out_pc1    = q_pc[head1];
         end
      end
   end

endmodule
